// File: rtl/rl_hs_pkg.sv
// Shared types and helpers for the dav_/rfd handshake receiver.
package rl_hs_pkg;

    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned DEF_CNTW  = 16;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } hs_state_e;

    // Unsigned magnitude of a signed byte; |-128| is 0x80.
    function automatic logic [7:0] abs8(input logic [7:0] x);
        return x[7] ? (~x + 8'd1) : x;
    endfunction

endpackage

// File: rtl/rl_sync_fifo.sv
// DEPTH x 8 synchronous FIFO; head holds the last popped byte while empty.
module rl_sync_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [7:0]                 din_i,
    output logic [7:0]                 head_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       empty_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    last_q, last_d;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && (level_q != '0);
    assign do_push = push_i && (level_q != FULL_LVL);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            last_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        level_d = level_q + LW'(do_push) - LW'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            last_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            last_q   <= last_d;
        end
    end

    assign empty_o = (level_q == '0);
    assign head_o  = empty_o ? last_q : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/rl_dav_rfd_receiver.sv
// Consumer side of the dav_/rfd byte handshake: FSM, FIFO buffering and rx statistics.
module rl_dav_rfd_receiver
    import rl_hs_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNTW  = DEF_CNTW
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   dav_,
    input  logic [7:0]             A,
    output logic                   rfd,
    output logic [7:0]             q,
    output logic                   q_valid,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNTW-1:0]        rx_count,
    output logic [7:0]             max_abs
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    hs_state_e       state_q, state_d;
    logic            rfd_q, rfd_d;
    logic [CNTW-1:0] rx_count_q, rx_count_d;
    logic [7:0]      max_abs_q, max_abs_d;
    logic [7:0]      a_abs;
    logic            push;
    logic            empty;

    always_comb begin
        state_d = state_q;
        rfd_d   = rfd_q;
        push    = 1'b0;
        unique case (state_q)
            S_SYNC: begin
                rfd_d = 1'b1;
                if (dav_) state_d = S_WAIT;
            end
            S_WAIT: begin
                rfd_d = 1'b1;
                // Full check uses the pre-edge level, so a same-edge pop cannot admit a push.
                if (!dav_ && (level != FULL_LVL)) begin
                    push    = 1'b1;
                    rfd_d   = 1'b0;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                rfd_d = 1'b0;
                if (dav_) begin
                    rfd_d   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            default: begin
                rfd_d   = 1'b1;
                state_d = S_SYNC;
            end
        endcase
    end

    always_comb begin
        a_abs      = abs8(A);
        rx_count_d = rx_count_q + CNTW'(push);
        max_abs_d  = max_abs_q;
        if (push && (a_abs > max_abs_q)) max_abs_d = a_abs;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_SYNC;
            rfd_q      <= 1'b1;
            rx_count_q <= '0;
            max_abs_q  <= '0;
        end else begin
            state_q    <= state_d;
            rfd_q      <= rfd_d;
            rx_count_q <= rx_count_d;
            max_abs_q  <= max_abs_d;
        end
    end

    rl_sync_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .push_i (push),
        .pop_i  (pop),
        .din_i  (A),
        .head_o (q),
        .level_o(level),
        .empty_o(empty)
    );

    assign q_valid  = ~empty;
    assign rfd      = rfd_q;
    assign rx_count = rx_count_q;
    assign max_abs  = max_abs_q;

endmodule

// File: tb/tb_rl_dav_rfd_receiver.sv
// Directed bench for rl_dav_rfd_receiver (DEPTH=4, CNTW=4 so the counter wrap is reachable).
module tb_rl_dav_rfd_receiver;

    logic       clock = 1'b0;
    logic       reset;
    logic       dav_;
    logic [7:0] A;
    logic       rfd;
    logic [7:0] q;
    logic       q_valid;
    logic       pop;
    logic [2:0] level;
    logic [3:0] rx_count;
    logic [7:0] max_abs;

    int total = 0;
    int bad   = 0;

    rl_dav_rfd_receiver #(
        .DEPTH(4),
        .CNTW (4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .dav_    (dav_),
        .A       (A),
        .rfd     (rfd),
        .q       (q),
        .q_valid (q_valid),
        .pop     (pop),
        .level   (level),
        .rx_count(rx_count),
        .max_abs (max_abs)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full handshake with no pop: offer, taken on first edge, release.
    task automatic xfer(input logic [7:0] b);
        A    = b;
        dav_ = 1'b0;
        tick();
        dav_ = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        dav_  = 1'b1;
        A     = 8'h00;
        pop   = 1'b0;
        tick();
        tick();
        chk("rst_rfd", 16'(rfd), 16'h1);
        chk("rst_qv", 16'(q_valid), 16'h0);
        chk("rst_level", 16'(level), 16'h0);
        chk("rst_cnt", 16'(rx_count), 16'h0);
        chk("rst_max", 16'(max_abs), 16'h0);
        chk("rst_q", 16'(q), 16'h0);

        // Single byte
        reset = 1'b0;
        tick();
        tick();
        A    = 8'h05;
        dav_ = 1'b0;
        tick();
        chk("t1_rfd0", 16'(rfd), 16'h0);
        chk("t1_q", 16'(q), 16'h05);
        chk("t1_qv", 16'(q_valid), 16'h1);
        chk("t1_cnt", 16'(rx_count), 16'h1);
        chk("t1_max", 16'(max_abs), 16'h05);
        dav_ = 1'b1;
        tick();
        chk("t1_rfd1", 16'(rfd), 16'h1);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("t1_pop_level", 16'(level), 16'h0);
        chk("t1_pop_qv", 16'(q_valid), 16'h0);

        // Fill: four bytes fit, fifth stalls until a slot frees
        for (int i = 0; i < 4; i++) xfer(8'h10 + 8'(i));
        chk("t2_level4", 16'(level), 16'h4);
        chk("t2_cnt5", 16'(rx_count), 16'h5);
        A    = 8'h14;
        dav_ = 1'b0;
        tick();
        tick();
        chk("t2_full_rfd", 16'(rfd), 16'h1);
        chk("t2_full_level", 16'(level), 16'h4);
        chk("t2_full_cnt", 16'(rx_count), 16'h5);
        chk("t2_head10", 16'(q), 16'h10);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("t2_pop_level", 16'(level), 16'h3);
        chk("t2_pop_rfd", 16'(rfd), 16'h1);
        chk("t2_pop_head", 16'(q), 16'h11);
        tick();
        chk("t2_late_rfd", 16'(rfd), 16'h0);
        chk("t2_late_level", 16'(level), 16'h4);
        chk("t2_late_cnt", 16'(rx_count), 16'h6);
        dav_ = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", 16'(q), 16'h11 + 16'(i));
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        chk("t2_drained", 16'(level), 16'h0);
        chk("t2_max", 16'(max_abs), 16'h14);

        // Abs/max after a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        xfer(8'h7F);
        chk("t3_max7f", 16'(max_abs), 16'h7F);
        xfer(8'h80);
        chk("t3_max80", 16'(max_abs), 16'h80);
        xfer(8'hFF);
        chk("t3_maxff", 16'(max_abs), 16'h80);
        chk("t3_cnt", 16'(rx_count), 16'h3);
        chk("t3_level", 16'(level), 16'h3);
        for (int i = 0; i < 3; i++) begin
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end

        // Reset while in S_ACK with dav_ still low
        A    = 8'h55;
        dav_ = 1'b0;
        tick();
        chk("t4_ack_rfd", 16'(rfd), 16'h0);
        chk("t4_ack_cnt", 16'(rx_count), 16'h4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_rst_rfd", 16'(rfd), 16'h1);
        chk("t4_rst_level", 16'(level), 16'h0);
        tick();
        tick();
        chk("t4_nocap_cnt", 16'(rx_count), 16'h0);
        chk("t4_nocap_level", 16'(level), 16'h0);
        chk("t4_nocap_rfd", 16'(rfd), 16'h1);
        dav_ = 1'b1;
        tick();
        A    = 8'h22;
        dav_ = 1'b0;
        tick();
        chk("t4_new_cnt", 16'(rx_count), 16'h1);
        chk("t4_new_q", 16'(q), 16'h22);
        chk("t4_new_max", 16'(max_abs), 16'h22);
        dav_ = 1'b1;
        tick();

        // Simultaneous push and pop at level 2
        xfer(8'h33);
        chk("t5_level2", 16'(level), 16'h2);
        A    = 8'h44;
        dav_ = 1'b0;
        pop  = 1'b1;
        tick();
        pop  = 1'b0;
        dav_ = 1'b1;
        chk("t5_level", 16'(level), 16'h2);
        chk("t5_head", 16'(q), 16'h33);
        chk("t5_cnt", 16'(rx_count), 16'h3);
        tick();
        pop = 1'b1;
        tick();
        chk("t5_tail", 16'(q), 16'h44);
        tick();
        pop = 1'b0;
        chk("t5_empty", 16'(level), 16'h0);

        // Counter wrap with CNTW=4: 17 transfers -> 1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 17; i++) begin
            A    = 8'(i);
            dav_ = 1'b0;
            tick();
            dav_ = 1'b1;
            pop  = 1'b1;
            tick();
            pop  = 1'b0;
            if (i == 15) chk("t6_wrap0", 16'(rx_count), 16'h0);
        end
        chk("t6_cnt", 16'(rx_count), 16'h1);
        chk("t6_level", 16'(level), 16'h0);
        chk("t6_max", 16'(max_abs), 16'h10);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("t6_emptypop_level", 16'(level), 16'h0);
        chk("t6_emptypop_qv", 16'(q_valid), 16'h0);
        chk("t6_hold_q", 16'(q), 16'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
